// File: rtl/spi_write.sv
// SPI transmit shifter: sends a BYTE_SIZE-byte word MSB-first on MOSI, one bit per
// spiClock rising edge, then optional trailing idle bits; level start / held finish.
//   state | meaning
//   IDLE  | waiting for start, MOSI at IDLE_BIT
//   SHIFT | payload bits being driven
//   TRAIL | trailing IDLE_BIT cycles (SD Ncr/Nwr gap)
//   DONE  | finish held until start drops
module spi_write #(
    parameter int   BYTE_SIZE  = 1,
    parameter int   TRAIL_BITS = 0,
    parameter logic IDLE_BIT   = 1'b1
) (
    input  logic                   spiClock,
    input  logic                   nReset,
    input  logic                   start,
    input  logic [BYTE_SIZE*8-1:0] byteIn,
    output logic                   bitOut,
    output logic                   busy,
    output logic                   finish
);

    localparam int N  = BYTE_SIZE * 8;
    localparam int CW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);
    localparam int TW = ($clog2(TRAIL_BITS + 1) < 1) ? 1 : $clog2(TRAIL_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_TRAIL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    // The MSB goes straight to bitOut on the accepting edge, so only N-1 bits remain.
    logic [N-2:0]    shreg;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tcnt;

    always_ff @(posedge spiClock or negedge nReset) begin
        if (!nReset) begin
            state  <= S_IDLE;
            bitOut <= IDLE_BIT;
            busy   <= 1'b0;
            finish <= 1'b0;
            shreg  <= '0;
            cnt    <= '0;
            tcnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg  <= byteIn[N-2:0];
                        bitOut <= byteIn[N-1];
                        cnt    <= CW'(N - 1);
                        busy   <= 1'b1;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!start) begin
                        bitOut <= IDLE_BIT;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else if (cnt != '0) begin
                        bitOut <= shreg[N-2];
                        shreg  <= {shreg[N-3:0], 1'b0};
                        cnt    <= cnt - 1'b1;
                    end else begin
                        bitOut <= IDLE_BIT;
                        if (TRAIL_BITS > 0) begin
                            tcnt  <= TW'(TRAIL_BITS - 1);
                            state <= S_TRAIL;
                        end else begin
                            finish <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_DONE;
                        end
                    end
                end
                S_TRAIL: begin
                    bitOut <= IDLE_BIT;
                    if (!start) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (tcnt != '0) begin
                        tcnt <= tcnt - 1'b1;
                    end else begin
                        finish <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    bitOut <= IDLE_BIT;
                    if (!start) begin
                        finish <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    bitOut <= IDLE_BIT;
                    busy   <= 1'b0;
                    finish <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_write.sv
// Bench for spi_write: a 1-byte instance and a 6-byte/8-trail-bit instance driven
// with directed and random words, compared against an edge-indexed stream model.
module tb_spi_write;

    logic        spiClock = 1'b0;
    logic        nReset;
    logic        start1, start6;
    logic [7:0]  byteIn1;
    logic [47:0] byteIn6;
    logic        bitOut1, busy1, finish1;
    logic        bitOut6, busy6, finish6;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 spiClock = ~spiClock;

    spi_write #(.BYTE_SIZE(1), .TRAIL_BITS(0), .IDLE_BIT(1'b1)) dut1 (
        .spiClock(spiClock), .nReset(nReset), .start(start1), .byteIn(byteIn1),
        .bitOut(bitOut1), .busy(busy1), .finish(finish1)
    );

    spi_write #(.BYTE_SIZE(6), .TRAIL_BITS(8), .IDLE_BIT(1'b1)) dut6 (
        .spiClock(spiClock), .nReset(nReset), .start(start6), .byteIn(byteIn6),
        .bitOut(bitOut6), .busy(busy6), .finish(finish6)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start1 = v;
        else start6 = v;
    endtask

    task automatic set_byte(input int sel, input logic [47:0] w);
        if (sel == 0) byteIn1 = w[7:0];
        else byteIn6 = w;
    endtask

    task automatic chk_out(input int sel, input string tag,
                           input logic eb, input logic ebusy, input logic efin);
        logic b, bz, f;
        b  = (sel == 0) ? bitOut1 : bitOut6;
        bz = (sel == 0) ? busy1   : busy6;
        f  = (sel == 0) ? finish1 : finish6;
        chk({tag, "_bit"},    48'(b),  48'(eb));
        chk({tag, "_busy"},   48'(bz), 48'(ebusy));
        chk({tag, "_finish"}, 48'(f),  48'(efin));
        chk({tag, "_excl"},   48'(bz & f), 48'd0);
    endtask

    // Full transfer: edge k shows payload bit N-1-k, then ones; finish after edge N+T.
    task automatic xfer(input int sel, input logic [47:0] w, input int n, input int t,
                        input int hold, input bit corrupt);
        logic eb;
        @(negedge spiClock);
        set_byte(sel, w);
        set_start(sel, 1'b1);
        for (int k = 0; k <= n + t; k++) begin
            @(posedge spiClock); #1;
            if (k == 0 && corrupt) set_byte(sel, ~w);
            eb = (k < n) ? w[n-1-k] : 1'b1;
            chk_out(sel, $sformatf("xfer_e%0d", k), eb, (k < n + t), (k == n + t));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge spiClock); #1;
            chk_out(sel, "hold", 1'b1, 1'b0, 1'b1);
        end
        @(negedge spiClock);
        set_start(sel, 1'b0);
        @(posedge spiClock); #1;
        chk_out(sel, "release", 1'b1, 1'b0, 1'b0);
    endtask

    // Start held for edges 0..a-1, dropped on edge a.
    task automatic abort_xfer(input int sel, input logic [47:0] w, input int n, input int a);
        @(negedge spiClock);
        set_byte(sel, w);
        set_start(sel, 1'b1);
        for (int k = 0; k < a; k++) begin
            @(posedge spiClock); #1;
            chk_out(sel, "abort_pre", (k < n) ? w[n-1-k] : 1'b1, 1'b1, 1'b0);
        end
        @(negedge spiClock);
        set_start(sel, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge spiClock); #1;
            chk_out(sel, "abort_post", 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [63:0] r64;
        nReset  = 1'b0;
        start1  = 1'b0;
        start6  = 1'b0;
        byteIn1 = '0;
        byteIn6 = '0;
        #12;
        chk_out(0, "reset1", 1'b1, 1'b0, 1'b0);
        chk_out(1, "reset6", 1'b1, 1'b0, 1'b0);
        @(negedge spiClock);
        nReset = 1'b1;

        // Directed 0xA5
        xfer(0, 48'hA5, 8, 0, 0, 1'b0);

        // Asynchronous reset mid-payload, while bit 3 (0) of 0xA5 is on the line
        @(negedge spiClock);
        byteIn1 = 8'hA5;
        start1  = 1'b1;
        repeat (5) @(posedge spiClock);
        #1;
        chk("rst_pre_bit", 48'(bitOut1), 48'd0);
        #2;
        nReset = 1'b0;
        #1;
        chk_out(0, "rst_async", 1'b1, 1'b0, 1'b0);
        @(negedge spiClock);
        start1 = 1'b0;
        nReset = 1'b1;
        @(posedge spiClock); #1;
        chk_out(0, "rst_after", 1'b1, 1'b0, 1'b0);

        // Abort of 0x00 after edge 3, then a clean reload
        abort_xfer(0, 48'h00, 8, 4);
        xfer(0, 48'h5A, 8, 0, 0, 1'b0);

        // Hold start 20 edges past finish, then a second word
        xfer(0, 48'hC3, 8, 0, 20, 1'b0);
        xfer(0, 48'h3C, 8, 0, 0, 1'b0);

        // byteIn changes after edge 0 must not affect the word in flight
        xfer(0, 48'hFF, 8, 0, 0, 1'b1);

        // Random words, holds, byteIn disturbance and aborts
        for (int i = 0; i < 6; i++) begin
            xfer(0, 48'($urandom_range(0, 255)), 8, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) begin
            abort_xfer(0, 48'($urandom_range(0, 255)), 8, $urandom_range(1, 8));
        end

        // Six-byte instance: CMD0 with 8 trailing ones, then random word and abort
        xfer(1, 48'h400000000095, 48, 8, 2, 1'b1);
        r64 = {$urandom, $urandom};
        xfer(1, r64[47:0], 48, 8, 0, 1'b0);
        r64 = {$urandom, $urandom};
        abort_xfer(1, r64[47:0], 48, $urandom_range(50, 55));
        xfer(1, 48'h400000000095, 48, 8, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
